// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and decoded-amount struct shared by the shifter pipeline
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    typedef struct packed {
        sh_op_e     op;
        logic [7:0] amount_eff;
        logic       is_zero;
        logic       is_ge_w;
        logic       is_rrx;
    } sh_dec_t;

endpackage

// File: rtl/shift_amount_decode.sv
// rtl/shift_amount_decode.sv - folds ARM immediate/register amount rules into a flat decoded op
module shift_amount_decode
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0] sh_i,
    input  logic       imm_i,
    input  logic [7:0] amt_i,
    output sh_dec_t    dec_o
);
    localparam int LW = $clog2(WIDTH);

    sh_op_e     op;
    logic [7:0] imm_n;

    assign op    = sh_op_e'(sh_i);
    assign imm_n = 8'(amt_i[LW-1:0]);

    always_comb begin
        dec_o    = '0;
        dec_o.op = op;
        if (imm_i) begin
            dec_o.amount_eff = imm_n;
            // Immediate #0 is an escape: LSR/ASR mean a full-width shift, ROR means RRX.
            if (imm_n == 8'd0) begin
                case (op)
                    SH_LSL:  dec_o.is_zero = 1'b1;
                    SH_ROR:  dec_o.is_rrx  = 1'b1;
                    default: begin
                        dec_o.amount_eff = 8'(WIDTH);
                        dec_o.is_ge_w    = 1'b1;
                    end
                endcase
            end
        end else begin
            dec_o.amount_eff = amt_i;
            dec_o.is_zero    = (amt_i == 8'd0);
            dec_o.is_ge_w    = (op != SH_ROR) && (amt_i >= 8'(WIDTH));
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - ARM shifter operand with log2 barrel, carry select and valid/ready pipeline
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       Sh,
    input  logic             ShImm,
    input  logic [7:0]       ShAmt,
    input  logic [WIDTH-1:0] ShIn,
    input  logic             CarryIn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ShOut,
    output logic             CarryOut,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LW        = $clog2(WIDTH);
    localparam int LO_LEVELS = LW / 2;
    localparam logic [LW-1:0] IDX_ONE  = LW'(1);
    localparam logic [LW-1:0] IDX_ZERO = '0;

    typedef struct packed {
        sh_dec_t          dec;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] orig;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } beat_t;

    function automatic logic [WIDTH-1:0] barrel_level(input logic [WIDTH-1:0] d,
                                                      input sh_op_e op, input int k);
        int s;
        s = 1 << k;
        case (op)
            SH_LSL:  barrel_level = d << s;
            SH_LSR:  barrel_level = d >> s;
            SH_ASR:  barrel_level = $signed(d) >>> s;
            default: barrel_level = (d >> s) | (d << (WIDTH - s));
        endcase
    endfunction

    function automatic beat_t run_levels(input beat_t b, input int lo, input int hi);
        beat_t r;
        r = b;
        for (int k = hi; k >= lo; k--) begin
            if (r.dec.amount_eff[k]) r.data = barrel_level(r.data, r.dec.op, k);
        end
        return r;
    endfunction

    logic             en;
    logic             out_valid_q;
    logic [WIDTH-1:0] sh_out_q;
    logic             carry_q;
    logic [TAG_W-1:0] tag_q;

    sh_dec_t dec;
    beat_t   dec_stage_d, dec_stage, upper_stage_d, upper_stage, lower_stage;
    logic    dec_valid, upper_valid;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    shift_amount_decode #(.WIDTH(WIDTH)) u_decode (
        .sh_i  (Sh),
        .imm_i (ShImm),
        .amt_i (ShAmt),
        .dec_o (dec)
    );

    assign dec_stage_d = '{dec: dec, data: ShIn, orig: ShIn, cin: CarryIn, tag: in_tag};

    if (PIPE >= 2) begin : g_dec_reg
        beat_t dec_stage_q;
        logic  dec_valid_q;
        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset) begin
                dec_stage_q <= '0;
                dec_valid_q <= 1'b0;
            end else if (en) begin
                dec_valid_q <= in_valid;
                if (in_valid) dec_stage_q <= dec_stage_d;
            end
        end
        assign dec_stage = dec_stage_q;
        assign dec_valid = dec_valid_q;
    end else begin : g_dec_comb
        assign dec_stage = dec_stage_d;
        assign dec_valid = in_valid;
    end

    assign upper_stage_d = run_levels(dec_stage, LO_LEVELS, LW - 1);

    if (PIPE >= 3) begin : g_upper_reg
        beat_t upper_stage_q;
        logic  upper_valid_q;
        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset) begin
                upper_stage_q <= '0;
                upper_valid_q <= 1'b0;
            end else if (en) begin
                upper_valid_q <= dec_valid;
                if (dec_valid) upper_stage_q <= upper_stage_d;
            end
        end
        assign upper_stage = upper_stage_q;
        assign upper_valid = upper_valid_q;
    end else begin : g_upper_comb
        assign upper_stage = upper_stage_d;
        assign upper_valid = dec_valid;
    end

    assign lower_stage = run_levels(upper_stage, 0, LO_LEVELS - 1);

    logic [LW-1:0]    amt_lo, lsl_idx, lsr_idx;
    logic             eq_w;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;

    // W-n and n-1 wrap harmlessly outside 0<n<W; those cases never select them.
    assign amt_lo  = lower_stage.dec.amount_eff[LW-1:0];
    assign lsl_idx = IDX_ZERO - amt_lo;
    assign lsr_idx = amt_lo - IDX_ONE;
    assign eq_w    = (lower_stage.dec.amount_eff == 8'(WIDTH));

    always_comb begin
        result_d = lower_stage.data;
        carry_d  = lower_stage.cin;
        if (lower_stage.dec.is_zero) begin
            result_d = lower_stage.orig;
        end else if (lower_stage.dec.is_rrx) begin
            result_d = {lower_stage.cin, lower_stage.orig[WIDTH-1:1]};
            carry_d  = lower_stage.orig[0];
        end else begin
            case (lower_stage.dec.op)
                SH_LSL: begin
                    if (lower_stage.dec.is_ge_w) begin
                        result_d = '0;
                        carry_d  = eq_w & lower_stage.orig[0];
                    end else begin
                        carry_d = lower_stage.orig[lsl_idx];
                    end
                end
                SH_LSR: begin
                    if (lower_stage.dec.is_ge_w) begin
                        result_d = '0;
                        carry_d  = eq_w & lower_stage.orig[WIDTH-1];
                    end else begin
                        carry_d = lower_stage.orig[lsr_idx];
                    end
                end
                SH_ASR: begin
                    if (lower_stage.dec.is_ge_w) begin
                        result_d = {WIDTH{lower_stage.orig[WIDTH-1]}};
                        carry_d  = lower_stage.orig[WIDTH-1];
                    end else begin
                        carry_d = lower_stage.orig[lsr_idx];
                    end
                end
                default: carry_d = lower_stage.data[WIDTH-1];
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            sh_out_q    <= '0;
            carry_q     <= 1'b0;
            tag_q       <= '0;
        end else if (en) begin
            out_valid_q <= upper_valid;
            if (upper_valid) begin
                sh_out_q <= result_d;
                carry_q  <= carry_d;
                tag_q    <= lower_stage.tag;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ShOut     = sh_out_q;
    assign CarryOut  = carry_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - scoreboard bench for pipelined_shifter (WIDTH=32, PIPE=2)
module tb_pipelined_shifter;
    localparam int WIDTH = 32;
    localparam int PIPE  = 2;
    localparam int TAG_W = 4;

    logic             CLK       = 1'b0;
    logic             Reset     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [1:0]       Sh        = '0;
    logic             ShImm     = 1'b0;
    logic [7:0]       ShAmt     = '0;
    logic [WIDTH-1:0] ShIn      = '0;
    logic             CarryIn   = 1'b0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] ShOut;
    logic             CarryOut;
    logic [TAG_W-1:0] out_tag;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             c;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t             sb_q[$];
    int               total = 0;
    int               bad   = 0;
    int               rcv   = 0;
    logic [TAG_W-1:0] tag_ctr = '0;

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_d;
    logic             prev_c;
    logic [TAG_W-1:0] prev_t;

    pipelined_shifter #(.WIDTH(WIDTH), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sh        (Sh),
        .ShImm     (ShImm),
        .ShAmt     (ShAmt),
        .ShIn      (ShIn),
        .CarryIn   (CarryIn),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ShOut     (ShOut),
        .CarryOut  (CarryOut),
        .out_tag   (out_tag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] sh, input logic imm, input logic [7:0] amt,
                        input logic [WIDTH-1:0] din, input logic cin,
                        input logic [WIDTH-1:0] exp_d, input logic exp_c);
        int w;
        in_valid = 1'b1;
        Sh       = sh;
        ShImm    = imm;
        ShAmt    = amt;
        ShIn     = din;
        CarryIn  = cin;
        in_tag   = tag_ctr;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 200) check("in_ready_timeout", 64'(in_ready), 64'd1);
        sb_q.push_back('{d: exp_d, c: exp_c, t: tag_ctr});
        tag_ctr++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: pops expected results on every handshake and watches stalls for stability.
    always @(negedge CLK) begin
        exp_t e;
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_stable_data", 64'(ShOut), 64'(prev_d));
                check("stall_stable_carry", 64'(CarryOut), 64'(prev_c));
                check("stall_stable_tag", 64'(out_tag), 64'(prev_t));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%0h required=none", ShOut);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("shout_tag%0d", e.t), 64'(ShOut), 64'(e.d));
                    check($sformatf("carry_tag%0d", e.t), 64'(CarryOut), 64'(e.c));
                    check("tag_order", 64'(out_tag), 64'(e.t));
                    rcv++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = ShOut;
            prev_c     = CarryOut;
            prev_t     = out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 Reset = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_shout", 64'(ShOut), 64'd0);
        check("rst_carry", 64'(CarryOut), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);

        // Sh, imm, amount, operand, CarryIn -> expected result, carry
        send(2'b00, 1'b0, 8'd32,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1);
        send(2'b00, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        send(2'b10, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(2'b10, 1'b0, 8'd7,   32'h8000_0000, 1'b1, 32'hFF00_0000, 1'b0);
        send(2'b11, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        send(2'b11, 1'b0, 8'd40,  32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0);
        send(2'b11, 1'b0, 8'd32,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1);
        send(2'b00, 1'b1, 8'h20,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
        send(2'b01, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        send(2'b00, 1'b1, 8'hE4,  32'h1234_5678, 1'b0, 32'h2345_6780, 1'b1);
        send(2'b01, 1'b0, 8'd4,   32'h1234_5678, 1'b0, 32'h0123_4567, 1'b1);
        send(2'b01, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        send(2'b10, 1'b0, 8'd40,  32'h7000_0000, 1'b1, 32'h0000_0000, 1'b0);
        send(2'b11, 1'b1, 8'd4,   32'h1234_5678, 1'b0, 32'h8123_4567, 1'b1);
        send(2'b11, 1'b0, 8'd0,   32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1);
        send(2'b01, 1'b0, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        send(2'b10, 1'b0, 8'd31,  32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
        send(2'b00, 1'b0, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        send(2'b11, 1'b0, 8'd1,   32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1);
        send(2'b10, 1'b1, 8'd5,   32'h8000_0020, 1'b1, 32'hFC00_0001, 1'b0);
        send(2'b11, 1'b0, 8'd63,  32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0);
        send(2'b10, 1'b0, 8'd21,  32'h8765_4321, 1'b1, 32'hFFFF_FC3B, 1'b0);
        send(2'b10, 1'b0, 8'd255, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        idle();
        drain("drain_directed");

        // 8 back-to-back beats, tags 0..7, consumer stalls for 3 cycles mid-stream
        tag_ctr = '0;
        rcv     = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(2'b00, 1'b0, 8'(i), 32'h8000_0001, 1'b0,
                         (i == 0) ? 32'h8000_0001 : (32'h1 << i), (i == 1));
                end
                idle();
            end
            begin
                repeat (3) @(posedge CLK);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge CLK);
                #2 out_ready = 1'b1;
            end
        join
        drain("drain_stream");
        check("stream_count", 64'(rcv), 64'd8);

        // Reset with two beats in flight while the consumer is stalled
        @(posedge CLK);
        #2 out_ready = 1'b0;
        @(negedge CLK);
        send(2'b01, 1'b0, 8'd1, 32'h0000_00F0, 1'b0, 32'h0000_0078, 1'b0);
        send(2'b01, 1'b0, 8'd2, 32'h0000_00F0, 1'b0, 32'h0000_003C, 1'b0);
        idle();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_shout", 64'(ShOut), 64'd0);
        sb_q.delete();
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("no_stale_after_reset", 64'(out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
